// File: rtl/frame_buffer_pkg.sv
// Shared definitions for the frame buffer arbiter: default widths, the
// arbiter state encoding and the layout of one queued camera write.
package frame_buffer_pkg;

  localparam int FB_ADDR_W       = 19;
  localparam int FB_DATA_W       = 8;
  localparam int FB_FRAME_PIXELS = 307200;
  localparam int FB_FIFO_LOG     = 3;

  // SYNC_WAIT: camera not yet aligned to a frame, pixels ignored.
  // STREAM:    camera pixels are addressed and queued for the BRAM.
  typedef enum logic {
    SYNC_WAIT = 1'b0,
    STREAM    = 1'b1
  } arb_state_e;

  // One pending BRAM write: raster address plus luma value.
  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] pixel;
  } fb_entry_t;

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO holding camera writes until the BRAM port is free.
// Depth is 2**FIFO_LOG. A push while full is accepted only when a pop happens
// in the same cycle; a pop while empty is ignored. Head data is combinational
// from the storage array so the arbiter can issue the write in the same cycle.
module pixel_fifo
  import frame_buffer_pkg::*;
#(
  parameter int  FIFO_LOG = FB_FIFO_LOG,
  parameter type entry_t  = fb_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int DEPTH = 1 << FIFO_LOG;

  entry_t               mem [DEPTH];
  logic [FIFO_LOG:0]    wr_idx;
  logic [FIFO_LOG:0]    rd_idx;
  logic                 do_push;
  logic                 do_pop;

  // Extra index bit distinguishes full from empty when the low bits match.
  assign empty   = (wr_idx == rd_idx);
  assign full    = (wr_idx[FIFO_LOG] != rd_idx[FIFO_LOG]) &&
                   (wr_idx[FIFO_LOG-1:0] == rd_idx[FIFO_LOG-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_idx[FIFO_LOG-1:0]];

  // Advance read/write indices; reset discards all queued entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      if (do_push) wr_idx <= wr_idx + (FIFO_LOG+1)'(1);
      if (do_pop)  rd_idx <= rd_idx + (FIFO_LOG+1)'(1);
    end
  end

  // Store the pushed entry; contents need no reset since indices gate reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx[FIFO_LOG-1:0]] <= push_data;
  end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Frame buffer arbiter: shares one single-port frame BRAM between the camera
// pixel writer and the VGA reader. Camera pixels get a raster address and are
// queued in pixel_fifo; VGA reads win the port unless the queue is full.
//
// Optional feature: define DROP_COUNT_EN to build the saturating dropped-pixel
// counter behind drop_count; otherwise drop_count is tied to zero.
//
// Handshake semantics: there is no back-pressure on either client. cam_valid
// is a one-cycle pixel strobe and is either queued or dropped (overflow).
// vga_req is a one-cycle read strobe; it is either granted (vga_rvalid three
// cycles later with vga_rdata) or lost to a full-queue write (vga_miss one
// cycle later). Exactly one of those two outcomes follows every vga_req.
module frame_buffer_arbiter
  import frame_buffer_pkg::*;
#(
  parameter int ADDR_W       = FB_ADDR_W,
  parameter int DATA_W       = FB_DATA_W,
  parameter int FRAME_PIXELS = FB_FRAME_PIXELS,
  parameter int FIFO_LOG     = FB_FIFO_LOG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cam_valid,
  input  logic [DATA_W-1:0] cam_pixel,
  input  logic              cam_frame_start,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_rvalid,
  output logic              vga_miss,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic              overflow,
  output logic [15:0]       drop_count,
  output arb_state_e        dbg_state
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] pixel;
  } entry_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  arb_state_e        state;
  arb_state_e        state_next;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] pix_addr;
  logic              cam_live;
  logic              push_req;
  logic              drop;
  entry_t            push_entry;
  entry_t            fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              grant_write;
  logic              grant_read;
  logic              rd_s1;
  logic              rd_s2;

  // ---------------------------------------------------------------------
  // Frame sync FSM
  // ---------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= SYNC_WAIT;
    else       state <= state_next;
  end

  // Leave SYNC_WAIT on the first frame start; STREAM is held until reset.
  always_comb begin
    state_next = state;
    if (state == SYNC_WAIT && cam_frame_start) state_next = STREAM;
  end

  assign dbg_state = state;

  // ---------------------------------------------------------------------
  // Camera side: addressing and queueing
  // ---------------------------------------------------------------------

  // The frame-start pixel itself is live even while still in SYNC_WAIT.
  assign cam_live   = (state == STREAM) || cam_frame_start;
  assign push_req   = cam_live && cam_valid;
  assign pix_addr   = cam_frame_start ? '0 : wr_ptr;
  assign push_entry = {pix_addr, cam_pixel};

  // Raster address tracks every live camera pixel, dropped or not, so the
  // pixels after a drop still land at their true screen position.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
    end else if (push_req) begin
      wr_ptr <= (pix_addr == LAST_ADDR) ? '0 : pix_addr + ADDR_W'(1);
    end else if (cam_frame_start) begin
      wr_ptr <= '0;
    end
  end

  pixel_fifo #(
    .FIFO_LOG (FIFO_LOG),
    .entry_t  (entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (push_entry),
    .pop       (grant_write),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ---------------------------------------------------------------------
  // Port arbitration: full queue > VGA read > pending write > idle
  // ---------------------------------------------------------------------
  assign grant_write = fifo_full || (!vga_req && !fifo_empty);
  assign grant_read  = vga_req && !fifo_full;

  // A pixel is lost only when the queue is full and nothing leaves it.
  assign drop = push_req && fifo_full && !grant_write;

  // Registered BRAM port; address holds when the port is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bram_addr  <= '0;
      bram_we    <= 1'b0;
      bram_wdata <= '0;
    end else if (grant_write) begin
      bram_addr  <= fifo_head.addr;
      bram_we    <= 1'b1;
      bram_wdata <= fifo_head.pixel;
    end else if (grant_read) begin
      bram_addr  <= vga_addr;
      bram_we    <= 1'b0;
    end else begin
      bram_we    <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // VGA side: read return pipeline and miss pulse
  // ---------------------------------------------------------------------

  // Track granted reads through address, BRAM latency and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_s1      <= 1'b0;
      rd_s2      <= 1'b0;
      vga_rvalid <= 1'b0;
      vga_rdata  <= '0;
      vga_miss   <= 1'b0;
    end else begin
      rd_s1      <= grant_read;
      rd_s2      <= rd_s1;
      vga_rvalid <= rd_s2;
      if (rd_s2) vga_rdata <= bram_rdata;
      vga_miss   <= vga_req && !grant_read;
    end
  end

  // ---------------------------------------------------------------------
  // Drop reporting
  // ---------------------------------------------------------------------

  // Sticky overflow; a frame start clears it unless it drops a pixel itself.
  always_ff @(posedge clk) begin
    if (reset)                overflow <= 1'b0;
    else if (cam_frame_start) overflow <= drop;
    else if (drop)            overflow <= 1'b1;
  end

`ifdef DROP_COUNT_EN
  logic [15:0] drop_cnt;

  // Saturating per-frame count of dropped pixels.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (cam_frame_start) begin
      drop_cnt <= {15'b0, drop};
    end else if (drop && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign drop_count = drop_cnt;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Bench for frame_buffer_arbiter: directed stimulus, expected BRAM writes,
// VGA read returns and VGA misses queued as stimulus is issued, and a
// negedge monitor that pops and compares whenever the DUT presents one.
module tb_frame_buffer_arbiter;
  import frame_buffer_pkg::*;

  localparam int AW = 19;
  localparam int DW = 8;
  localparam int FP = 64;  // short frame so the wrap is reached quickly

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          cam_valid;
  logic [DW-1:0] cam_pixel;
  logic          cam_frame_start;
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_rdata;
  logic          vga_rvalid;
  logic          vga_miss;
  logic [AW-1:0] bram_addr;
  logic          bram_we;
  logic [DW-1:0] bram_wdata;
  logic [DW-1:0] bram_rdata = '0;
  logic          overflow;
  logic [15:0]   drop_count;
  arb_state_e    dbg_state;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  frame_buffer_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .FRAME_PIXELS(FP), .FIFO_LOG(3)
  ) dut (
    .clk(clk), .reset(reset),
    .cam_valid(cam_valid), .cam_pixel(cam_pixel), .cam_frame_start(cam_frame_start),
    .vga_req(vga_req), .vga_addr(vga_addr),
    .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid), .vga_miss(vga_miss),
    .bram_addr(bram_addr), .bram_we(bram_we), .bram_wdata(bram_wdata),
    .bram_rdata(bram_rdata),
    .overflow(overflow), .drop_count(drop_count), .dbg_state(dbg_state)
  );

  // ---------------- BRAM model (read-first, 1 cycle) ----------------
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bram_we) mem[bram_addr] <= bram_wdata;
    bram_rdata <= mem[bram_addr];
  end

  // ---------------- scoreboard ----------------
  logic [AW+DW-1:0] exp_wr_q[$];
  logic [DW-1:0]    exp_rd_q[$];
  int               exp_rd_cyc_q[$];
  int               exp_miss_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic exp_write(input int a, input int p);
    logic [AW-1:0] aa;
    logic [DW-1:0] pp;
    aa = a[AW-1:0];
    pp = p[DW-1:0];
    exp_wr_q.push_back({aa, pp});
  endtask

  logic [AW+DW-1:0] mon_w;
  logic [DW-1:0]    mon_d;
  int               mon_c;

  // Monitor: every DUT output event is matched against the expected queues.
  always @(negedge clk) begin
    if (bram_we) begin
      tests++;
      if (exp_wr_q.size() == 0) begin
        fails++;
        $display("FAIL bram_write: got unexpected write addr %0d data 0x%0h, none required", bram_addr, bram_wdata);
      end else begin
        mon_w = exp_wr_q.pop_front();
        if ({bram_addr, bram_wdata} !== mon_w) begin
          fails++;
          $display("FAIL bram_write: got addr %0d data 0x%0h required addr %0d data 0x%0h",
                   bram_addr, bram_wdata, mon_w[AW+DW-1:DW], mon_w[DW-1:0]);
        end
      end
    end
    if (vga_rvalid) begin
      tests++;
      if (exp_rd_q.size() == 0) begin
        fails++;
        $display("FAIL vga_read: got unexpected rvalid data 0x%0h at cycle %0d", vga_rdata, cyc);
      end else begin
        mon_d = exp_rd_q.pop_front();
        mon_c = exp_rd_cyc_q.pop_front();
        if (vga_rdata !== mon_d || cyc != mon_c) begin
          fails++;
          $display("FAIL vga_read: got data 0x%0h at cycle %0d required 0x%0h at cycle %0d",
                   vga_rdata, cyc, mon_d, mon_c);
        end
      end
    end
    if (vga_miss) begin
      tests++;
      if (exp_miss_q.size() == 0) begin
        fails++;
        $display("FAIL vga_miss: got unexpected miss at cycle %0d", cyc);
      end else begin
        mon_c = exp_miss_q.pop_front();
        if (cyc != mon_c) begin
          fails++;
          $display("FAIL vga_miss: got miss at cycle %0d required cycle %0d", cyc, mon_c);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Apply one cycle of inputs (called just after a negedge), then wait a cycle.
  task automatic drive(input logic fs, input logic v, input logic [DW-1:0] p,
                       input logic rq, input logic [AW-1:0] ra);
    cam_frame_start = fs;
    cam_valid       = v;
    cam_pixel       = p;
    vga_req         = rq;
    vga_addr        = ra;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic check_drop_count(input string name, input int enabled_value);
`ifdef DROP_COUNT_EN
    check(name, 32'(drop_count), 32'(enabled_value));
`else
    check(name, 32'(drop_count), 32'd0);
`endif
  endtask

  // Watchdog: the sequence is bounded, this only catches a stuck simulator.
  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: got timeout at cycle %0d required completion", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    cam_valid = 1'b0; cam_pixel = '0; cam_frame_start = 1'b0;
    vga_req = 1'b0; vga_addr = '0;
    mem[1000] = 8'h5C;
    for (int k = 0; k < 20; k++) mem[5000 + k] = 8'hC0 + 8'(k);
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_bram_addr", 32'(bram_addr), 32'd0);
    check("rst_bram_we", 32'(bram_we), 32'd0);
    check("rst_bram_wdata", 32'(bram_wdata), 32'd0);
    check("rst_vga_rdata", 32'(vga_rdata), 32'd0);
    check("rst_vga_rvalid", 32'(vga_rvalid), 32'd0);
    check("rst_vga_miss", 32'(vga_miss), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(SYNC_WAIT));
    reset = 1'b0;

    // T1: pixels before any frame start are ignored
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 8'h30 + 8'(i), 1'b0, '0);
    idle(3);
    check("t1_overflow", 32'(overflow), 32'd0);
    check("t1_drop_count", 32'(drop_count), 32'd0);
    check("t1_state", 32'(dbg_state), 32'(SYNC_WAIT));

    // T2: frame start + 0xAA, then 0xBB; first write two cycles later
    exp_write(0, 8'hAA);
    drive(1'b1, 1'b1, 8'hAA, 1'b0, '0);
    check("t2_we_at_n1", 32'(bram_we), 32'd0);
    exp_write(1, 8'hBB);
    drive(1'b0, 1'b1, 8'hBB, 1'b0, '0);
    check("t2_we_at_n2", 32'(bram_we), 32'd1);
    check("t2_addr_at_n2", 32'(bram_addr), 32'd0);
    check("t2_wdata_at_n2", 32'(bram_wdata), 32'hAA);
    check("t2_state", 32'(dbg_state), 32'(STREAM));
    idle(4);

    // T3: single read of preloaded 0x5C at 1000, returns at N+3
    exp_rd_q.push_back(8'h5C);
    exp_rd_cyc_q.push_back(cyc + 3);
    drive(1'b0, 1'b0, '0, 1'b1, AW'(1000));
    idle(5);

    // T4: read and pixel every cycle; queue fills after 8 pushes, then every
    // cycle is a full-queue write and that cycle's read is missed
    for (int k = 0; k < 20; k++) begin
      exp_write(2 + k, 8'h10 + k);
      if (k < 8) begin
        exp_rd_q.push_back(8'hC0 + 8'(k));
        exp_rd_cyc_q.push_back(cyc + 3);
      end else begin
        exp_miss_q.push_back(cyc + 1);
      end
      drive(1'b0, 1'b1, 8'h10 + 8'(k), 1'b1, AW'(5000 + k));
    end
    idle(12);
    check("t4_overflow", 32'(overflow), 32'd0);
    check_drop_count("t4_drop_count", 0);

    // T5: hold the write grant off so the queue fills and pixels drop
    force dut.grant_write = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_write(22 + k, 8'h50 + k);
      drive(1'b0, 1'b1, 8'h50 + 8'(k), 1'b0, '0);
    end
    check("t5_full_no_drop_overflow", 32'(overflow), 32'd0);
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 8'hE0 + 8'(k), 1'b0, '0);
    check("t5_overflow", 32'(overflow), 32'd1);
    check_drop_count("t5_drop_count", 3);
    drive(1'b1, 1'b1, 8'hEF, 1'b0, '0);
    check("t5_fs_drop_overflow", 32'(overflow), 32'd1);
    check_drop_count("t5_fs_drop_count", 1);
    release dut.grant_write;
    idle(12);
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    check("t5_fs_clear_overflow", 32'(overflow), 32'd0);
    check_drop_count("t5_fs_clear_drop_count", 0);
    idle(2);

    // T6: FP+6 pixels wrap FP-1 -> 0; reset lands while one pixel is queued
    for (int i = 0; i < FP + 6; i++) begin
      if (i <= FP + 4) exp_write((i < FP) ? i : i - FP, 8'h80 + i);
      drive(i == 0, 1'b1, 8'h80 + 8'(i), 1'b0, '0);
    end
    reset = 1'b1;
    drive(1'b0, 1'b1, 8'hFF, 1'b0, '0);
    check("t6_we_after_reset", 32'(bram_we), 32'd0);
    check("t6_addr_after_reset", 32'(bram_addr), 32'd0);
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    reset = 1'b0;
    check("t6_state_after_reset", 32'(dbg_state), 32'(SYNC_WAIT));
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'h99, 1'b0, '0);
    exp_write(0, 8'h77);
    drive(1'b1, 1'b1, 8'h77, 1'b0, '0);
    idle(5);

    // Every expected event must have been seen
    check("end_wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
    check("end_rd_q_empty", 32'(exp_rd_q.size()), 32'd0);
    check("end_miss_q_empty", 32'(exp_miss_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frame_buffer_arbiter.md
# frame_buffer_arbiter

Shares the single-port 640x480x8 frame BRAM between the camera pixel writer and the VGA display reader. Camera pixels are tagged with a raster address, buffered in a small FIFO and written when the port is free. VGA reads get priority except when the FIFO is full. Sits between the camera capture path, the BRAM and the VGA pixel fetch logic.

## Interface
- ADDR_W, 19, BRAM address width
- DATA_W, 8, pixel width (luma)
- FRAME_PIXELS, 307200, pixels per frame; write address wraps here
- FIFO_LOG, 3, log2 write FIFO depth (8 entries)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cam_valid  in  1  one-cycle pulse per captured pixel
- cam_pixel  in  DATA_W  pixel data, qualified by cam_valid
- cam_frame_start  in  1  pulse marking first pixel of a new frame
- vga_req  in  1  read request, one per cycle max
- vga_addr  in  ADDR_W  read address, qualified by vga_req
- vga_rdata  out  DATA_W  read data
- vga_rvalid  out  1  vga_rdata valid
- vga_miss  out  1  pulse: a request was not serviced
- bram_addr  out  ADDR_W  BRAM address (registered)
- bram_we  out  1  BRAM write enable (registered)
- bram_wdata  out  DATA_W  BRAM write data (registered)
- bram_rdata  in  DATA_W  BRAM read data, 1 cycle after bram_addr
- overflow  out  1  sticky: camera pixel dropped
- drop_count  out  16  dropped pixel count (see Configuration)

## Operation
- States: SYNC_WAIT (reset state; camera pixels ignored, not counted), STREAM. SYNC_WAIT -> STREAM on cam_frame_start. No other transitions except reset.
- Write address counter wr_ptr: cam_frame_start sets it to 0 for the pixel on that cycle. Each accepted pixel pushes {wr_ptr, cam_pixel}; wr_ptr increments, FRAME_PIXELS-1 -> 0.
- cam_valid and cam_frame_start together: pixel gets address 0, wr_ptr becomes 1.
- Arbitration, per cycle: if FIFO full, write wins; else if vga_req, read wins; else if FIFO non-empty, write wins; else idle (bram_we=0, bram_addr holds).
- vga_req lost to a full-FIFO write: no vga_rvalid for it; vga_miss pulses instead.
- Push while full: pixel accepted if the same cycle pops, otherwise dropped, overflow set.
- overflow cleared by reset or cam_frame_start. Reads are never queued.
- Reset outputs: bram_addr 0, bram_we 0, bram_wdata 0, vga_rdata 0, vga_rvalid 0, vga_miss 0, overflow 0, drop_count 0; FIFO empty, wr_ptr 0, state SYNC_WAIT.
- Reset mid-operation discards FIFO contents and in-flight reads; no BRAM write after reset is asserted.

## Timing
- Read: vga_req at cycle N -> bram_addr=vga_addr, bram_we=0 in N+1 -> bram_rdata N+2 -> vga_rdata/vga_rvalid registered in N+3. Throughput 1/cycle.
- vga_miss asserted in N+1 for a request lost at N.
- Write: cam_valid at N -> FIFO entry visible N+1 -> earliest bram_we in N+2 with matching bram_addr/bram_wdata.
- Back-to-back vga_req every cycle with FIFO not full: FIFO drains only on full; each full cycle costs one read.

## Configuration
- DROP_COUNT_EN defined: drop_count counts dropped pixels, saturates at 65535, cleared by reset and cam_frame_start (a drop on the same cycle gives 1).
- Undefined: drop_count constant 0, counter logic absent; overflow unchanged.

## Structure
- Package frame_buffer_pkg: ADDR_W, DATA_W, FRAME_PIXELS defaults, arbiter state enum {SYNC_WAIT, STREAM}, FIFO entry struct {addr, pixel}.
- Sub-module pixel_fifo: synchronous FIFO, 2^FIFO_LOG entries, push/pop/full/empty, simultaneous push+pop when full allowed. Arbiter logic in the top.

## Test plan
- Reset, no cam_frame_start, 10 cam_valid -> no bram_we, overflow 0, drop_count 0.
- cam_frame_start+cam_valid pixel 0xAA, then 0xBB, no vga_req -> bram_we writes 0xAA@0 then 0xBB@1, first at cycle+2.
- Preload BRAM 0x5C@1000; vga_req addr 1000 at N -> vga_rvalid and vga_rdata 0x5C in N+3.
- vga_req every cycle, cam_valid every cycle for 20 cycles -> FIFO fills, writes on full cycles, vga_miss pulses; no pixel dropped, overflow 0.
- Force FIFO full and hold it (cam_valid with pop blocked by read priority test hook or 2 pixels/cycle model) -> overflow 1, drop_count (DROP_COUNT_EN) equals drops; cam_frame_start clears both.
- Stream FRAME_PIXELS+2 pixels -> last writes at 307199, 0, 1; reset mid-stream -> bram_we 0 next cycle, FIFO empty.
